// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, 1-cycle-read-latency
// byte-lane memory between the instruction port (I) and data port (D).
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   i_req..i_wdata     I request bundle, held stable until i_gnt
//   i_gnt              I accepted this cycle (combinational)
//   i_rvalid/rdata/err I response, one cycle after a read/illegal grant
//   d_*                same set for the data port
//   mem_*              shared memory bus; mem_data_out is registered data
module mem_port_arbiter #(
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_width,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_width,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_width,
  output logic        mem_write_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic        r_last_d;
  logic [3:0]  r_wait;
  logic [1:0]  r_owner;
  logic        r_err;

  logic        w_i_win;
  logic        w_d_win;
  logic        w_gnt;
  logic        w_legal;
  logic [31:0] w_addr;
  logic [3:0]  w_width;
  logic        w_write;
  logic [31:0] w_wdata;
  logic        w_i_own;
  logic        w_d_own;

  // Winner selection; nothing is granted while in reset.
  always_comb begin
    w_i_win = 1'b0;
    w_d_win = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        (i_req && !d_req): w_i_win = 1'b1;
        (d_req && !i_req): w_d_win = 1'b1;
        (i_req && d_req): begin
          if (MODE == 0)
            w_i_win = (r_wait == LP_MAX);
          else
            w_i_win = r_last_d;
          w_d_win = !w_i_win;
        end
        default: ;
      endcase
    end
  end

  assign w_gnt = w_i_win | w_d_win;
  assign i_gnt = w_i_win;
  assign d_gnt = w_d_win;

  always_comb begin
    w_addr  = w_d_win ? d_addr  : i_addr;
    w_width = w_d_win ? d_width : i_width;
    w_write = w_d_win ? d_write : i_write;
    w_wdata = w_d_win ? d_wdata : i_wdata;
  end

  always_comb begin
    case (w_width)
      4'd1:    w_legal = 1'b1;
      4'd2:    w_legal = !w_addr[0];
      4'd4:    w_legal = (w_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal grants leave the bus idle so memory is never touched.
  always_comb begin
    mem_address  = '0;
    mem_width    = '0;
    mem_write_en = 1'b0;
    mem_data_in  = '0;
    if (w_gnt && w_legal) begin
      mem_address  = w_addr;
      mem_width    = w_width;
      mem_write_en = w_write;
      mem_data_in  = w_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_d <= 1'b1;
      r_wait   <= '0;
      r_owner  <= OWN_NONE;
      r_err    <= 1'b0;
    end else begin
      if (w_gnt)
        r_last_d <= w_d_win;
      if (i_req && !w_i_win) begin
        if (r_wait != LP_MAX)
          r_wait <= r_wait + 4'd1;
      end else begin
        r_wait <= '0;
      end
      // Only reads and rejected requests owe a response.
      if (w_gnt && (!w_write || !w_legal)) begin
        r_owner <= w_d_win ? OWN_D : OWN_I;
        r_err   <= !w_legal;
      end else begin
        r_owner <= OWN_NONE;
        r_err   <= 1'b0;
      end
    end
  end

  assign w_i_own  = !reset && (r_owner == OWN_I);
  assign w_d_own  = !reset && (r_owner == OWN_D);

  assign i_rvalid = w_i_own;
  assign i_err    = w_i_own && r_err;
  assign i_rdata  = (w_i_own && !r_err) ? mem_data_out : '0;

  assign d_rvalid = w_d_own;
  assign d_err    = w_d_own && r_err;
  assign d_rdata  = (w_d_own && !r_err) ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives a MODE0 and a MODE1 arbiter, each with
// its own memory, and scoreboards grants, bus and responses.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  w;
    logic        wr;
    logic [31:0] wd;
    int          gap;
    logic        hk;
    logic [31:0] kv;
  } req_t;

  typedef struct {
    int          due;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst = 1'b1;
  bit   rst_req = 1'b1;

  // index: dut*2 + port, port 0 = I, 1 = D
  logic        s_req [4];
  logic [31:0] s_addr[4];
  logic [3:0]  s_wid [4];
  logic        s_wr  [4];
  logic [31:0] s_wd  [4];
  logic        o_gnt [4];
  logic        o_rv  [4];
  logic [31:0] o_rd  [4];
  logic        o_er  [4];

  logic [31:0] ma [2];
  logic [3:0]  mw [2];
  logic        mwe[2];
  logic [31:0] mdi[2];
  logic [31:0] mdo[2];

  mem_port_arbiter #(.MODE(0), .MAX_WAIT(4)) u0 (
    .clock(clock), .reset(rst),
    .i_req(s_req[0]), .i_addr(s_addr[0]), .i_width(s_wid[0]),
    .i_write(s_wr[0]), .i_wdata(s_wd[0]), .i_gnt(o_gnt[0]),
    .i_rvalid(o_rv[0]), .i_rdata(o_rd[0]), .i_err(o_er[0]),
    .d_req(s_req[1]), .d_addr(s_addr[1]), .d_width(s_wid[1]),
    .d_write(s_wr[1]), .d_wdata(s_wd[1]), .d_gnt(o_gnt[1]),
    .d_rvalid(o_rv[1]), .d_rdata(o_rd[1]), .d_err(o_er[1]),
    .mem_address(ma[0]), .mem_width(mw[0]),
    .mem_write_en(mwe[0]), .mem_data_in(mdi[0]),
    .mem_data_out(mdo[0])
  );

  mem_port_arbiter #(.MODE(1), .MAX_WAIT(4)) u1 (
    .clock(clock), .reset(rst),
    .i_req(s_req[2]), .i_addr(s_addr[2]), .i_width(s_wid[2]),
    .i_write(s_wr[2]), .i_wdata(s_wd[2]), .i_gnt(o_gnt[2]),
    .i_rvalid(o_rv[2]), .i_rdata(o_rd[2]), .i_err(o_er[2]),
    .d_req(s_req[3]), .d_addr(s_addr[3]), .d_width(s_wid[3]),
    .d_write(s_wr[3]), .d_wdata(s_wd[3]), .d_gnt(o_gnt[3]),
    .d_rvalid(o_rv[3]), .d_rdata(o_rd[3]), .d_err(o_er[3]),
    .mem_address(ma[1]), .mem_width(mw[1]),
    .mem_write_en(mwe[1]), .mem_data_in(mdi[1]),
    .mem_data_out(mdo[1])
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  req_t rq[4][$];
  rsp_t sq[4][$];
  bit   active[4];
  int   waited[4];
  int   mwait[2];
  int   mlast[2];

  logic [7:0] emem[2][512];
  bit         ev  [2][512];
  logic [7:0] rmem[2][512];

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 13 + 7);
  endfunction

  function automatic int bidx(input logic [31:0] a, input int j);
    return int'((a + 32'(j)) & 32'h1ff);
  endfunction

  function automatic logic [31:0] erd(input int k,
                                      input logic [31:0] a,
                                      input logic [3:0] w);
    logic [31:0] v;
    int x;
    v = '0;
    for (int j = 0; j < int'(w) && j < 4; j++) begin
      x = bidx(a, j);
      v[8*j+:8] = ev[k][x] ? emem[k][x] : pat(x);
    end
    return v;
  endfunction

  function automatic logic [31:0] rrd(input int k,
                                      input logic [31:0] a,
                                      input logic [3:0] w);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < int'(w) && j < 4; j++)
      v[8*j+:8] = rmem[k][bidx(a, j)];
    return v;
  endfunction

  // Memory environment: byte lanes, little-endian, registered read.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (mw[k] != 4'd0) begin
        if (mwe[k]) begin
          for (int j = 0; j < int'(mw[k]) && j < 4; j++) begin
            emem[k][bidx(ma[k], j)] <= mdi[k][8*j+:8];
            ev[k][bidx(ma[k], j)]   <= 1'b1;
          end
        end else begin
          mdo[k] <= erd(k, ma[k], mw[k]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=0x%08h want=0x%08h",
               nm, k, cyc, act, exp);
    end
  endtask

  task automatic pushr(input int idx, input logic [31:0] a,
                       input logic [3:0] w, input logic wrb,
                       input logic [31:0] d, input int gap,
                       input logic hk, input logic [31:0] kv);
    req_t r;
    r.a = a; r.w = w; r.wr = wrb; r.wd = d;
    r.gap = gap; r.hk = hk; r.kv = kv;
    rq[idx].push_back(r);
  endtask

  function automatic bit is_legal(input req_t r);
    return (r.w == 4'd1) ||
           (r.w == 4'd2 && !r.a[0]) ||
           (r.w == 4'd4 && r.a[1:0] == 2'b00);
  endfunction

  // Reference: grant rules, scoreboard push, reference memory update.
  task automatic evaluate();
    for (int k = 0; k < 2; k++) begin
      int ii;
      int di;
      int win;
      int idx;
      req_t r;
      rsp_t e;
      ii = 2 * k;
      di = ii + 1;
      win = -1;
      if (rst) begin
        chk("rst_gnt", k, {30'b0, o_gnt[ii], o_gnt[di]}, 0);
        chk("rst_mem", k,
            ma[k] | mdi[k] | {27'b0, mw[k], mwe[k]}, 0);
        mwait[k] = 0;
        mlast[k] = 1;
      end else begin
        if (s_req[ii] && !s_req[di])
          win = 0;
        else if (s_req[di] && !s_req[ii])
          win = 1;
        else if (s_req[ii] && s_req[di]) begin
          if (k == 0)
            win = (mwait[k] == 4) ? 0 : 1;
          else
            win = (mlast[k] == 0) ? 1 : 0;
        end
        chk("i_gnt", k, {31'b0, o_gnt[ii]}, 32'(win == 0));
        chk("d_gnt", k, {31'b0, o_gnt[di]}, 32'(win == 1));
        if (win < 0) begin
          chk("idle_mem", k,
              ma[k] | mdi[k] | {27'b0, mw[k], mwe[k]}, 0);
        end else begin
          idx = ii + win;
          r = rq[idx][0];
          if (!is_legal(r)) begin
            chk("ill_mem", k, {27'b0, mw[k], mwe[k]}, 0);
            e.due = cyc + 1; e.e = 1'b1; e.d = '0;
            sq[idx].push_back(e);
          end else begin
            chk("mem_addr", k, ma[k], r.a);
            chk("mem_ctl", k, {27'b0, mw[k], mwe[k]},
                {27'b0, r.w, r.wr});
            if (r.wr) begin
              chk("mem_wdata", k, mdi[k], r.wd);
              for (int j = 0; j < int'(r.w); j++)
                rmem[k][bidx(r.a, j)] = r.wd[8*j+:8];
            end else begin
              e.due = cyc + 1; e.e = 1'b0;
              e.d = r.hk ? r.kv : rrd(k, r.a, r.w);
              sq[idx].push_back(e);
            end
          end
        end
        if (s_req[ii] && win != 0)
          mwait[k] = (mwait[k] < 4) ? mwait[k] + 1 : 4;
        else
          mwait[k] = 0;
        if (win >= 0)
          mlast[k] = win;
      end
      for (int p = ii; p <= di; p++) begin
        if (o_gnt[p] && active[p]) begin
          void'(rq[p].pop_front());
          active[p] = 1'b0;
          waited[p] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    rst = rst_req;
    for (int i = 0; i < 4; i++) begin
      if (!active[i] && rq[i].size() > 0) begin
        if (waited[i] >= rq[i][0].gap) begin
          active[i] = 1'b1;
          s_req[i]  = 1'b1;
          s_addr[i] = rq[i][0].a;
          s_wid[i]  = rq[i][0].w;
          s_wr[i]   = rq[i][0].wr;
          s_wd[i]   = rq[i][0].wd;
        end else begin
          waited[i]++;
        end
      end
      if (!active[i]) begin
        s_req[i] = 1'b0; s_addr[i] = '0; s_wid[i] = '0;
        s_wr[i] = 1'b0;  s_wd[i] = '0;
      end
    end
    @(negedge clock);
    evaluate();
  endtask

  function automatic bit busy();
    for (int i = 0; i < 4; i++)
      if (rq[i].size() != 0 || active[i] || sq[i].size() != 0)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout cyc=%0d budget=%0d", cyc, budget);
      for (int i = 0; i < 4; i++) begin
        rq[i].delete();
        active[i] = 1'b0;
        waited[i] = 0;
      end
    end
    step();
  endtask

  // Monitor: pops the scoreboard whenever a response is due.
  always @(negedge clock) begin
    for (int idx = 0; idx < 4; idx++) begin
      if (rst) begin
        sq[idx].delete();
        chk("rst_rsp", idx / 2,
            o_rd[idx] | {30'b0, o_rv[idx], o_er[idx]}, 0);
      end else if (sq[idx].size() > 0 && sq[idx][0].due == cyc) begin
        rsp_t e;
        e = sq[idx].pop_front();
        chk((idx % 2) ? "d_rvalid" : "i_rvalid", idx / 2,
            {31'b0, o_rv[idx]}, 1);
        chk((idx % 2) ? "d_rdata" : "i_rdata", idx / 2, o_rd[idx], e.d);
        chk((idx % 2) ? "d_err" : "i_err", idx / 2,
            {31'b0, o_er[idx]}, {31'b0, e.e});
      end else begin
        chk((idx % 2) ? "d_no_rsp" : "i_no_rsp", idx / 2,
            {31'b0, o_rv[idx]}, 0);
      end
    end
  end

  logic [3:0] wt[10] = '{4'd1, 4'd2, 4'd4, 4'd1, 4'd2,
                         4'd4, 4'd4, 4'd3, 4'd0, 4'd8};

  initial begin
    for (int i = 0; i < 4; i++) begin
      s_req[i] = 1'b0; s_addr[i] = '0; s_wid[i] = '0;
      s_wr[i] = 1'b0;  s_wd[i] = '0;
      active[i] = 1'b0; waited[i] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      mwait[k] = 0;
      mlast[k] = 1;
      for (int a = 0; a < 512; a++)
        rmem[k][a] = pat(a);
    end

    rst_req = 1'b1;
    pushr(0, 32'h0, 4'd4, 1'b0, '0, 0, 1'b0, '0);
    pushr(3, 32'h4, 4'd4, 1'b0, '0, 0, 1'b0, '0);
    repeat (3) step();
    rst_req = 1'b0;

    // Only I reads four words.
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a += 4)
        pushr(2 * k, 32'(a), 4'd4, 1'b0, '0, 0, 1'b0, '0);
    drain(60);

    // Both ports continuously requesting.
    for (int n = 0; n < 12; n++)
      for (int i = 0; i < 4; i++)
        pushr(i, 32'($urandom_range(0, 127) * 4), 4'd4,
              1'b0, '0, 0, 1'b0, '0);
    drain(120);

    // Misaligned halfword write is rejected; memory is untouched.
    for (int k = 0; k < 2; k++) begin
      pushr(2 * k + 1, 32'h101, 4'd2, 1'b1, 32'h0000_A5A5,
            0, 1'b0, '0);
      pushr(2 * k + 1, 32'h100, 4'd4, 1'b0, '0, 0, 1'b1,
            {pat(32'h103), pat(32'h102), pat(32'h101), pat(32'h100)});
    end
    drain(40);

    // Store then fetch the same word on the next cycle.
    for (int k = 0; k < 2; k++) begin
      pushr(2 * k + 1, 32'h40, 4'd4, 1'b1, 32'hDEAD_BEEF,
            0, 1'b0, '0);
      pushr(2 * k, 32'h40, 4'd4, 1'b0, '0, 1, 1'b1, 32'hDEAD_BEEF);
      pushr(2 * k, 32'h43, 4'd1, 1'b0, '0, 0, 1'b1, 32'h0000_00DE);
    end
    drain(40);

    // Reset right after a read grant drops its response.
    pushr(0, 32'h8, 4'd4, 1'b0, '0, 0, 1'b0, '0);
    pushr(2, 32'h8, 4'd4, 1'b0, '0, 0, 1'b0, '0);
    step();
    rst_req = 1'b1;
    for (int i = 0; i < 4; i++)
      pushr(i, 32'(16 * (i + 1)), 4'd4, 1'b0, '0, 0, 1'b0, '0);
    step();
    step();
    rst_req = 1'b0;
    drain(40);

    // Randomized mixed traffic.
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 4; i++) begin
        logic [3:0]  w;
        logic [31:0] a;
        w = wt[$urandom_range(0, 9)];
        a = 32'($urandom_range(0, 511));
        if ($urandom_range(0, 3) != 0) begin
          if (w == 4'd2) a[0] = 1'b0;
          if (w == 4'd4) a[1:0] = 2'b00;
        end
        pushr(i, a, w, 1'($urandom_range(0, 9) < 4), $urandom,
              int'($urandom_range(0, 3)), 1'b0, '0);
      end
    end
    drain(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
